// File: rtl/result_sequencer.sv
// Result sequencer: snapshots NUM_CH results once the compute FIFO fills and drains,
// then presents them one word at a time to the serial transmitter with a pulse and a gap.
module result_sequencer #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     empty,
  input  logic [NUM_CH*DATA_W-1:0] results,
  input  logic                     tx_busy,
  output logic [DATA_W-1:0]        result_send,
  output logic                     pulse,
  output logic                     busy,
  output logic                     done
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_FIN = 3'd1,
    S_ARM      = 3'd2,
    S_SEND     = 3'd3,
    S_GAP      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_idx;
  logic [GAP_W-1:0]    r_gap;
  logic [DATA_W-1:0]   r_snap [NUM_CH];
  logic [DATA_W-1:0]   w_word;

  assign w_word = r_snap[r_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs decode from state and registered snapshot only, never from inputs.
  always_comb begin
    w_next      = r_state;
    result_send = '0;
    pulse       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!empty) w_next = S_WAIT_FIN;
      end
      S_WAIT_FIN: begin
        if (empty) w_next = S_ARM;
      end
      S_ARM: begin
        busy        = 1'b1;
        result_send = w_word;
        if (!tx_busy) w_next = S_SEND;
      end
      S_SEND: begin
        busy        = 1'b1;
        pulse       = 1'b1;
        result_send = w_word;
        w_next      = S_GAP;
      end
      S_GAP: begin
        busy        = 1'b1;
        result_send = w_word;
        if (r_gap == '0) begin
          w_next = (r_idx == LAST_IDX) ? S_DONE : S_ARM;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        result_send = w_word;
        w_next      = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // The index stays at the last channel through DONE, so DONE holds the final word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
      r_gap <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_snap[i] <= '0;
      end
    end else begin
      case (r_state)
        S_WAIT_FIN: begin
          if (empty) begin
            r_idx <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
              r_snap[i] <= results[i*DATA_W +: DATA_W];
            end
          end
        end
        S_SEND: begin
          r_gap <= GAP_LOAD;
        end
        S_GAP: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - GAP_W'(1);
          end else if (r_idx != LAST_IDX) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
